// File: rtl/imm_fold_pkg.sv
// imm_fold_pkg -- shared definitions for the immediate folder.
//   EOP_*        : extension-mode encodings of the immediate extender
//   state_t      : FSM state encodings of imm_fold
//   imm_ext()    : the forward extender (imm, EOp -> 32-bit value)
package imm_fold_pkg;

  localparam logic [1:0] EOP_SEXT     = 2'b00;  // sign-extend imm
  localparam logic [1:0] EOP_ZEXT     = 2'b01;  // zero-extend imm
  localparam logic [1:0] EOP_LUI      = 2'b10;  // imm in [31:16], low half zero
  localparam logic [1:0] EOP_SEXT_SL2 = 2'b11;  // sign-extend, then << 2

  localparam logic [1:0] LAST_MODE = EOP_SEXT_SL2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic [31:0] imm_ext(input logic [15:0] imm, input logic [1:0] eop);
    logic [31:0] ext;
    ext = {{16{imm[15]}}, imm};
    case (eop)
      EOP_SEXT:     ext = {{16{imm[15]}}, imm};
      EOP_ZEXT:     ext = {16'h0000, imm};
      EOP_LUI:      ext = {imm, 16'h0000};
      EOP_SEXT_SL2: ext = {{14{imm[15]}}, imm, 2'b00};
      default:      ext = {{16{imm[15]}}, imm};
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/imm_fold_match.sv
// imm_fold_match -- combinational check of one extension mode.
//   value [31:0] : constant being folded
//   mode  [1:0]  : extension mode under test
//   match        : extending imm under mode reproduces value exactly
//   imm   [15:0] : candidate immediate taken from value for this mode
module imm_fold_match
  import imm_fold_pkg::*;
(
  input  logic [31:0] value,
  input  logic [1:0]  mode,
  output logic        match,
  output logic [15:0] imm
);

  // Pick the only field that could encode value under this mode, then
  // push it back through the real extender: a round trip that returns
  // value is exactly the match condition for every mode.
  always_comb begin
    imm = value[15:0];
    case (mode)
      EOP_SEXT:     imm = value[15:0];
      EOP_ZEXT:     imm = value[15:0];
      EOP_LUI:      imm = value[31:16];
      EOP_SEXT_SL2: imm = value[17:2];
      default:      imm = value[15:0];
    endcase
  end

  assign match = (imm_ext(imm, mode) == value);

endmodule

// File: rtl/imm_fold.sv
// imm_fold -- inverse of the immediate extender: finds (imm, EOp) such that
// extending imm under EOp reproduces a 32-bit constant. One mode is tried
// per cycle in order 00..11; the lowest matching mode wins.
//   clk, reset   : clock, synchronous active-high reset
//   start, value : fold request; value sampled on the accepting edge
//   busy         : FSM in SCAN
//   done         : one-cycle result pulse
//   found/imm/EOp: result, held until the next accepted start
// Build option: define IMM_FOLD_EARLY_EXIT_EN to finish the scan on the
// first match instead of always evaluating all four modes.
module imm_fold
  import imm_fold_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [15:0] imm,
  output logic [1:0]  EOp
);

  state_t      state_q, state_d;
  logic [31:0] val_q;
  logic [1:0]  mode_q;
  logic        m_hit;
  logic [15:0] m_imm;
  logic        accept, rec, last;

  imm_fold_match u_match (
    .value (val_q),
    .mode  (mode_q),
    .match (m_hit),
    .imm   (m_imm)
  );

  // start is only honoured outside SCAN, so a running scan is never disturbed.
  assign accept = start && (state_q != ST_SCAN);
  // Only the first match is recorded; found guards later (higher) modes.
  assign rec    = (state_q == ST_SCAN) && m_hit && !found;
  assign last   = (mode_q == LAST_MODE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_SCAN;
`ifdef IMM_FOLD_EARLY_EXIT_EN
      ST_SCAN: if (rec || last) state_d = ST_DONE;
`else
      ST_SCAN: if (last) state_d = ST_DONE;
`endif
      ST_DONE: state_d = start ? ST_SCAN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      val_q   <= 32'h0;
      mode_q  <= 2'b00;
      found   <= 1'b0;
      imm     <= 16'h0000;
      EOp     <= 2'b00;
    end else begin
      state_q <= state_d;
      if (accept) begin
        val_q  <= value;
        mode_q <= 2'b00;
        found  <= 1'b0;
        imm    <= 16'h0000;
        EOp    <= 2'b00;
      end else if (state_q == ST_SCAN) begin
        mode_q <= mode_q + 2'd1;
        if (rec) begin
          found <= 1'b1;
          imm   <= m_imm;
          EOp   <= mode_q;
        end
      end
    end
  end

  // Pure decodes of the state register: no path from start.
  assign busy = (state_q == ST_SCAN);
  assign done = (state_q == ST_DONE);

endmodule
